spike_rate_display: RTL

- Downstream consumer of the LIF neuron's spike output.
- Counts rising edges of the spike line over a fixed gate window and latches the count at the end of each window.
- Drives the latched rate onto the single 7-segment display as one selectable hex nibble.
- Also produces a pulse-stretched spike LED and a one-cycle "new rate" strobe for the top level.

---
 rtl/spike_rate_display.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spike_rate_display.sv
// rtl/spike_rate_display.sv - gated spike-rate counter with 7-segment readout and stretched spike LED
//
// Counts rising edges of spike_in over a GATE_COUNT-cycle window, latches the
// saturating count into rate at the end of each window, and shows one hex
// nibble of it on a 7-segment display.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   spike_in   in   neuron spike level (same clock domain)
//   disp_sel   in   0 = show rate[3:0], 1 = show rate[7:4]
//   uo_out     out  [6:0] segments g..a active-high, [7] saturation flag
//   spike_led  out  stretched spike indicator
//   rate_valid out  one-cycle strobe with each newly latched rate
//   rate       out  latched edge count of the last complete window
module spike_rate_display #(
  parameter logic [23:0] GATE_COUNT = 24'd10_000_000,
  parameter int          CNT_W      = 8,
  parameter logic [23:0] STRETCH    = 24'd1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             disp_sel,
  output logic [7:0]       uo_out,
  output logic             spike_led,
  output logic             rate_valid,
  output logic [CNT_W-1:0] rate
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_spike_d;
  logic [CNT_W-1:0] r_acc;
  logic             r_acc_sat;
  logic [23:0]      r_win_cnt;
  logic [CNT_W-1:0] r_rate;
  logic             r_rate_sat;
  logic             r_rate_valid;
  logic [7:0]       r_uo;
  logic [23:0]      r_stretch;

  logic             w_edge;
  logic             w_terminal;
  logic             w_acc_at_max;
  logic [CNT_W-1:0] w_sum;
  logic [7:0]       w_rate8;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;

  assign w_edge       = spike_in & ~r_spike_d;
  assign w_terminal   = (r_win_cnt == GATE_COUNT - 24'd1);
  assign w_acc_at_max = (r_acc == CNT_MAX);
  // Saturating add of the edge bit: once at max the accumulator holds.
  assign w_sum        = w_acc_at_max ? r_acc : r_acc + CNT_W'(w_edge);

  // Zero-extend so the upper nibble reads as 0 for narrow counters.
  assign w_rate8  = 8'(r_rate);
  assign w_nibble = disp_sel ? w_rate8[7:4] : w_rate8[3:0];

  always_comb begin
    w_seg = 7'h00;
    case (w_nibble)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_d    <= 1'b0;
      r_acc        <= '0;
      r_acc_sat    <= 1'b0;
      r_win_cnt    <= 24'd0;
      r_rate       <= '0;
      r_rate_sat   <= 1'b0;
      r_rate_valid <= 1'b0;
      r_uo         <= 8'h00;
      r_stretch    <= 24'd0;
    end else begin
      r_spike_d    <= spike_in;
      r_uo         <= {r_rate_sat, w_seg};
      r_rate_valid <= w_terminal;

      // Each new edge restarts the LED hold time.
      if (w_edge) begin
        r_stretch <= STRETCH;
      end else if (r_stretch != 24'd0) begin
        r_stretch <= r_stretch - 24'd1;
      end

      if (w_terminal) begin
        // An edge on the terminal cycle is folded into the closing window.
        r_win_cnt  <= 24'd0;
        r_rate     <= w_sum;
        r_rate_sat <= r_acc_sat | (w_edge & w_acc_at_max);
        r_acc      <= '0;
        r_acc_sat  <= 1'b0;
      end else begin
        r_win_cnt <= r_win_cnt + 24'd1;
        r_acc     <= w_sum;
        if (w_edge & w_acc_at_max) begin
          r_acc_sat <= 1'b1;
        end
      end
    end
  end

  assign uo_out     = r_uo;
  assign spike_led  = (r_stretch != 24'd0);
  assign rate_valid = r_rate_valid;
  assign rate       = r_rate;

endmodule
